// File: rtl/updi_rx_engine.sv
// -----------------------------------------------------------------------------
// updi_rx_engine
//
// Consumes bytes from a UPDI RX FIFO on behalf of a command sequencer. A
// command (latched on start) either forwards n bytes to an output FIFO (PASS),
// drops n bytes (DISCARD, also used for the echo of transmitted bytes), or
// consumes a single byte and checks it against the ACK character (WAIT_ACK).
// Each byte takes two cycles: a pop cycle (WAIT) and a cycle where the popped
// byte is visible on in_fifo_data (LATCH). A per-byte timeout guards against
// a silent target.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   mode               0 PASS, 1 DISCARD, 2 WAIT_ACK, 3 treated as DISCARD
//   n_bytes            byte count (ignored in WAIT_ACK, which uses 1)
//   timeout_clks       per-byte timeout in cycles, 0 disables it
//   start, abort       command strobe / cancel of the active command
//   ready              engine idle, start will be accepted
//   done, timeout      one-cycle completion / timeout pulses
//   ack_received       one-cycle pulse when the WAIT_ACK byte is consumed
//   ack_error          with ack_received, when that byte was not ACK_BYTE
//   bytes_done         bytes consumed by the current or last command
//   in_fifo_*          RX FIFO (data valid the cycle after rd_en)
//   out_fifo_*         output FIFO
// -----------------------------------------------------------------------------
module updi_rx_engine #(
  parameter int          BITS_N    = 6,
  parameter int          TIMEOUT_W = 16,
  parameter logic [7:0]  ACK_BYTE  = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [BITS_N-1:0]    n_bytes,
  input  logic [TIMEOUT_W-1:0] timeout_clks,
  input  logic                 start,
  input  logic                 abort,
  output logic                 ready,
  output logic                 done,
  output logic                 timeout,
  output logic                 ack_received,
  output logic                 ack_error,
  output logic [BITS_N-1:0]    bytes_done,
  input  logic [7:0]           in_fifo_data,
  input  logic                 in_fifo_empty,
  output logic                 in_fifo_rd_en,
  output logic [7:0]           out_fifo_data,
  input  logic                 out_fifo_full,
  output logic                 out_fifo_wr_en
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_DISCARD  = 2'd1;
  localparam logic [1:0] MODE_WAIT_ACK = 2'd2;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [BITS_N-1:0]      count_q, count_d;
  logic [TIMEOUT_W-1:0]   tmo_lim_q, tmo_lim_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic [BITS_N-1:0]      bytes_done_q, bytes_done_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   ack_received_q, ack_received_d;
  logic                   ack_error_q, ack_error_d;

  logic                   pass_stall;
  logic                   pop_ok;
  logic [TIMEOUT_W:0]     timer_plus2;
  logic                   timer_hit;
  logic [BITS_N-1:0]      bytes_inc;

  // PASS must not pop a byte it has nowhere to put.
  assign pass_stall = (mode_q == MODE_PASS) && out_fifo_full;
  assign pop_ok     = (state_q == ST_WAIT) && !in_fifo_empty && !pass_stall;

  // The timer is cleared on entry to WAIT; the +2 accounts for the entry
  // edge itself and for the edge that registers the pulse, so that timeout
  // is seen exactly timeout_clks cycles after the start cycle.
  assign timer_plus2 = {1'b0, timer_q} + (TIMEOUT_W+1)'(2);
  assign timer_hit   = (tmo_lim_q != '0) && (timer_plus2 >= {1'b0, tmo_lim_q});

  assign bytes_inc = bytes_done_q + BITS_N'(1);

  // Decoded outputs. Gating with rst keeps a FIFO from being touched while
  // the engine is being reset mid-command.
  assign ready          = (state_q == ST_IDLE);
  assign in_fifo_rd_en  = pop_ok && rst;
  assign out_fifo_wr_en = (state_q == ST_LATCH) && (mode_q == MODE_PASS) && !abort && rst;
  assign out_fifo_data  = in_fifo_data;

  assign done         = done_q;
  assign timeout      = timeout_q;
  assign ack_received = ack_received_q;
  assign ack_error    = ack_error_q;
  assign bytes_done   = bytes_done_q;

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    count_d        = count_q;
    tmo_lim_d      = tmo_lim_q;
    timer_d        = timer_q;
    bytes_done_d   = bytes_done_q;
    done_d         = 1'b0;
    timeout_d      = 1'b0;
    ack_received_d = 1'b0;
    ack_error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_d       = (mode == 2'd3) ? MODE_DISCARD : mode;
          tmo_lim_d    = timeout_clks;
          timer_d      = '0;
          bytes_done_d = '0;
          count_d      = (mode == MODE_WAIT_ACK) ? BITS_N'(1) : n_bytes;
          if ((mode != MODE_WAIT_ACK) && (n_bytes == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pop_ok) begin
          state_d = ST_LATCH;
        end else if (in_fifo_empty) begin
          // Only a starved wait counts; a back-pressure stall holds the timer.
          if (timer_hit) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
        end
      end

      ST_LATCH: begin
        if (abort) begin
          // The byte on in_fifo_data is dropped and not counted.
          state_d = ST_IDLE;
        end else begin
          bytes_done_d = bytes_inc;
          if (bytes_inc == count_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (mode_q == MODE_WAIT_ACK) begin
              ack_received_d = 1'b1;
              ack_error_d    = (in_fifo_data != ACK_BYTE);
            end
          end else begin
            state_d = ST_WAIT;
            timer_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_PASS;
      count_q        <= '0;
      tmo_lim_q      <= '0;
      timer_q        <= '0;
      bytes_done_q   <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      ack_received_q <= 1'b0;
      ack_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      count_q        <= count_d;
      tmo_lim_q      <= tmo_lim_d;
      timer_q        <= timer_d;
      bytes_done_q   <= bytes_done_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      ack_received_q <= ack_received_d;
      ack_error_q    <= ack_error_d;
    end
  end

endmodule

// File: tb/tb_updi_rx_engine.sv
// -----------------------------------------------------------------------------
// tb_updi_rx_engine
//
// Directed bench for updi_rx_engine. Behavioural RX and output FIFOs surround
// the engine; inputs change on the falling edge and outputs are checked there.
// Cycle numbering in comments: the cycle in which start is high is cycle 0.
// -----------------------------------------------------------------------------
module tb_updi_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [5:0]  n_bytes;
  logic [15:0] timeout_clks;
  logic        start;
  logic        abort;
  logic        ready;
  logic        done;
  logic        timeout;
  logic        ack_received;
  logic        ack_error;
  logic [5:0]  bytes_done;
  logic [7:0]  in_fifo_data;
  logic        in_fifo_empty;
  logic        in_fifo_rd_en;
  logic [7:0]  out_fifo_data;
  logic        out_fifo_full;
  logic        out_fifo_wr_en;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  updi_rx_engine #(.BITS_N(6), .TIMEOUT_W(16), .ACK_BYTE(8'h40)) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .n_bytes        (n_bytes),
    .timeout_clks   (timeout_clks),
    .start          (start),
    .abort          (abort),
    .ready          (ready),
    .done           (done),
    .timeout        (timeout),
    .ack_received   (ack_received),
    .ack_error      (ack_error),
    .bytes_done     (bytes_done),
    .in_fifo_data   (in_fifo_data),
    .in_fifo_empty  (in_fifo_empty),
    .in_fifo_rd_en  (in_fifo_rd_en),
    .out_fifo_data  (out_fifo_data),
    .out_fifo_full  (out_fifo_full),
    .out_fifo_wr_en (out_fifo_wr_en)
  );

  // RX FIFO model: written by the stimulus, popped with one cycle latency.
  logic [7:0] rx_mem [0:255];
  int         rx_wr = 0;
  int         rx_rd = 0;
  assign in_fifo_empty = (rx_rd == rx_wr);

  always @(posedge clk) begin
    if (in_fifo_rd_en && (rx_rd != rx_wr)) begin
      in_fifo_data <= rx_mem[rx_rd[7:0]];
      rx_rd        <= rx_rd + 1;
    end
  end

  // Output FIFO model: records every pushed byte.
  logic [7:0] out_mem [0:255];
  int         out_cnt = 0;

  always @(posedge clk) begin
    if (out_fifo_wr_en) begin
      out_mem[out_cnt[7:0]] <= out_fifo_data;
      out_cnt               <= out_cnt + 1;
    end
  end

  // Pulse counters, sampled just after each rising edge.
  int done_cnt = 0, tmo_cnt = 0, ackr_cnt = 0, rd_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (done)          done_cnt++;
    if (timeout)       tmo_cnt++;
    if (ack_received)  ackr_cnt++;
    if (in_fifo_rd_en) rd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_mem[rx_wr[7:0]] = b;
    rx_wr++;
  endtask

  // Drives start for one cycle; returns at the falling edge of cycle 1.
  task automatic issue(input logic [1:0] m, input logic [5:0] n, input logic [15:0] t);
    mode         = m;
    n_bytes      = n;
    timeout_clks = t;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done, 1);
  endtask

  int base_out, base_done, base_tmo, base_ackr, base_rd;

  initial begin
    rst           = 1'b0;
    mode          = 2'd0;
    n_bytes       = '0;
    timeout_clks  = '0;
    start         = 1'b0;
    abort         = 1'b0;
    out_fifo_full = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_ack", {ack_received, ack_error}, 0);
    check_eq("rst_rd_wr", {in_fifo_rd_en, out_fifo_wr_en}, 0);
    check_eq("rst_bytes_done", bytes_done, 0);
    rst = 1'b1;
    @(negedge clk);

    // ---------------- PASS 9 bytes F1..F9 ----------------
    for (int i = 0; i < 9; i++) rx_push(8'hF1 + 8'(i));
    base_out = out_cnt;
    issue(2'd0, 6'd9, 16'd25);
    check_eq("pass_first_rd_en", in_fifo_rd_en, 1);
    check_eq("pass_busy", ready, 0);
    repeat (17) @(negedge clk);
    check_eq("pass_done_c18", done, 0);
    @(negedge clk);
    check_eq("pass_done_c19", done, 1);
    check_eq("pass_bytes_done", bytes_done, 9);
    check_eq("pass_ready", ready, 1);
    check_eq("pass_out_count", out_cnt - base_out, 9);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("pass_byte%0d", i), out_mem[base_out + i], 8'hF1 + 8'(i));
    check_eq("pass_rx_empty", in_fifo_empty, 1);

    // ---------------- n_bytes = 0 ----------------
    issue(2'd0, 6'd0, 16'd0);
    check_eq("zero_done", done, 1);
    check_eq("zero_ready", ready, 1);

    // ---------------- WAIT_ACK, good and bad byte ----------------
    base_out = out_cnt;
    rx_push(8'h40);
    issue(2'd2, 6'd5, 16'd0);
    repeat (2) @(negedge clk);
    check_eq("ack40_done", done, 1);
    check_eq("ack40_received", ack_received, 1);
    check_eq("ack40_error", ack_error, 0);
    check_eq("ack40_bytes_done", bytes_done, 1);
    rx_push(8'h41);
    issue(2'd2, 6'd5, 16'd0);
    repeat (2) @(negedge clk);
    check_eq("ack41_done", done, 1);
    check_eq("ack41_received", ack_received, 1);
    check_eq("ack41_error", ack_error, 1);
    check_eq("ack_out_untouched", out_cnt - base_out, 0);

    // ---------------- timeout 25 on an empty RX ----------------
    base_done = done_cnt;
    issue(2'd2, 6'd1, 16'd25);
    repeat (23) @(negedge clk);
    check_eq("tmo_c24", timeout, 0);
    check_eq("tmo_c24_busy", ready, 0);
    @(negedge clk);
    check_eq("tmo_c25", timeout, 1);
    check_eq("tmo_c25_ready", ready, 1);
    @(negedge clk);
    check_eq("tmo_c26", timeout, 0);
    check_eq("tmo_no_done", done_cnt - base_done, 0);

    // ---------------- timeout disabled ----------------
    base_tmo  = tmo_cnt;
    base_ackr = ackr_cnt;
    issue(2'd2, 6'd1, 16'd0);
    repeat (200) @(negedge clk);
    check_eq("notmo_count", tmo_cnt - base_tmo, 0);
    check_eq("notmo_busy", ready, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("notmo_abort_ready", ready, 1);
    check_eq("notmo_abort_no_ack", ackr_cnt - base_ackr, 0);

    // ---------------- abort has priority over start ----------------
    mode = 2'd0; n_bytes = 6'd1; timeout_clks = 16'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_ready", ready, 1);

    // ---------------- back-pressure ----------------
    out_fifo_full = 1'b1;
    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3);
    base_out = out_cnt; base_tmo = tmo_cnt; base_rd = rd_cnt; base_done = done_cnt;
    issue(2'd0, 6'd3, 16'd5);
    repeat (50) @(negedge clk);
    check_eq("bp_no_pop", rd_cnt - base_rd, 0);
    check_eq("bp_no_timeout", tmo_cnt - base_tmo, 0);
    check_eq("bp_busy", ready, 0);
    out_fifo_full = 1'b0;
    wait_done(20, "bp_done");
    check_eq("bp_out_count", out_cnt - base_out, 3);
    check_eq("bp_byte0", out_mem[base_out], 8'hA1);
    check_eq("bp_byte2", out_mem[base_out + 2], 8'hA3);
    check_eq("bp_bytes_done", bytes_done, 3);

    // ---------------- DISCARD 4 echo bytes ----------------
    for (int i = 0; i < 4; i++) rx_push(8'h50 + 8'(i));
    base_out = out_cnt;
    issue(2'd1, 6'd4, 16'd25);
    wait_done(20, "disc_done");
    check_eq("disc_rx_empty", in_fifo_empty, 1);
    check_eq("disc_out_untouched", out_cnt - base_out, 0);
    check_eq("disc_bytes_done", bytes_done, 4);

    // ---------------- PASS n=4, abort after 2 bytes ----------------
    rx_push(8'hC1); rx_push(8'hC2);
    base_out = out_cnt; base_done = done_cnt;
    issue(2'd0, 6'd4, 16'd0);
    begin
      int n;
      n = 0;
      while (bytes_done != 6'd2 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("abort_two_bytes", bytes_done, 2);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_ready", ready, 1);
    check_eq("abort_bytes_done", bytes_done, 2);
    check_eq("abort_no_done", done_cnt - base_done, 0);
    check_eq("abort_out_count", out_cnt - base_out, 2);

    // ---------------- full-range count 63 ----------------
    for (int i = 0; i < 63; i++) rx_push(8'(i));
    issue(2'd3, 6'd63, 16'd0);
    wait_done(200, "max_done");
    check_eq("max_bytes_done", bytes_done, 63);

    // ---------------- reset mid-PASS ----------------
    for (int i = 0; i < 4; i++) rx_push(8'hD1 + 8'(i));
    base_out = out_cnt; base_done = done_cnt;
    issue(2'd0, 6'd4, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;                       // cycle 3: waiting for the second byte
    @(negedge clk);
    check_eq("mrst_ready", ready, 1);
    check_eq("mrst_bytes_done", bytes_done, 0);
    check_eq("mrst_rd_wr", {in_fifo_rd_en, out_fifo_wr_en}, 0);
    check_eq("mrst_pulses", {done, timeout, ack_received, ack_error}, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_no_done", done_cnt - base_done, 0);
    issue(2'd0, 6'd3, 16'd25);
    wait_done(20, "mrst_restart_done");
    check_eq("mrst_out_count", out_cnt - base_out, 4);
    check_eq("mrst_byte1", out_mem[base_out + 1], 8'hD2);
    check_eq("mrst_byte3", out_mem[base_out + 3], 8'hD4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
